alu1: RTL and testbench

//   1-bit bit-slice ALU: eight operations on operands a/b with carry/borrow chain.

---
 rtl/alu1_pkg.sv | 15 +
 rtl/alu1_full_adder.sv | 13 +
 rtl/alu1.sv | 90 +++++++++
 tb/tb_alu1.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu1_pkg.sv
// Shared definitions for the 1-bit ALU slice and the multi-bit ALU built from it.
package alu1_pkg;

  typedef enum logic [2:0] {
    OP_AND      = 3'd0,
    OP_NOT      = 3'd1,
    OP_OR       = 3'd2,
    OP_XOR      = 3'd3,
    OP_ADD      = 3'd4,
    OP_SUB      = 3'd5,
    OP_TRANSFER = 3'd6,
    OP_TEST     = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu1_full_adder.sv
// Single-bit full adder; the carry/borrow primitive of the ALU slice.
module alu1_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/alu1.sv
// 1-bit bit-slice ALU with carry/borrow chain; outputs optionally registered.
module alu1
  import alu1_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       carry_in,
  input  logic [2:0] select,
  output logic       out,
  output logic       carry_out
);

  alu_op_e w_op;
  logic    w_add_sum;
  logic    w_add_cout;
  logic    w_sub_sum_n;
  logic    w_sub_borrow;
  logic    w_out;
  logic    w_cout;

  assign w_op = alu_op_e'(select);

  alu1_full_adder u_add (
    .a   (a),
    .b   (b),
    .cin (carry_in),
    .sum (w_add_sum),
    .cout(w_add_cout)
  );

  // a - b - bin: adding with ~a gives the borrow as carry and the inverted difference.
  alu1_full_adder u_sub (
    .a   (~a),
    .b   (b),
    .cin (carry_in),
    .sum (w_sub_sum_n),
    .cout(w_sub_borrow)
  );

  always_comb begin
    w_out  = 1'b0;
    w_cout = 1'b0;
    unique case (w_op)
      OP_AND:      w_out = a & b;
      OP_NOT:      w_out = ~a;
      OP_OR:       w_out = a | b;
      OP_XOR:      w_out = a ^ b;
      OP_ADD: begin
        w_out  = w_add_sum;
        w_cout = w_add_cout;
      end
      OP_SUB: begin
        w_out  = ~w_sub_sum_n;
        w_cout = w_sub_borrow;
      end
      OP_TRANSFER: w_out = a;
      OP_TEST:     w_out = ~a;
    endcase
  end

  generate
    if (REG_OUT) begin : g_reg
      logic r_out;
      logic r_cout;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_out  <= 1'b0;
          r_cout <= 1'b0;
        end else begin
          r_out  <= w_out;
          r_cout <= w_cout;
        end
      end

      assign out       = r_out;
      assign carry_out = r_cout;
    end else begin : g_comb
      logic w_unused;
      assign w_unused  = clk ^ rst_n;
      assign out       = w_out;
      assign carry_out = w_cout;
    end
  endgenerate

endmodule

// File: tb/tb_alu1.sv
// Bench for alu1: registered and combinational instances driven side by side.
module tb_alu1;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic       a;
    logic       b;
    logic       cin;
    logic [1:0] exp;  // {carry_out, out}
  } vec_t;

  typedef struct {
    string      name;
    logic [1:0] exp;
  } sb_t;

  logic       clk;
  logic       rst_n;
  logic       a;
  logic       b;
  logic       carry_in;
  logic [2:0] select;
  logic       out_reg;
  logic       cout_reg;
  logic       out_comb;
  logic       cout_comb;

  int   n_tests;
  int   n_fail;
  vec_t vecs[$];
  sb_t  sb[$];

  alu1 #(.REG_OUT(1'b1)) u_dut_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .select   (select),
    .out      (out_reg),
    .carry_out(cout_reg)
  );

  alu1 #(.REG_OUT(1'b0)) u_dut_comb (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .select   (select),
    .out      (out_comb),
    .carry_out(cout_comb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference: arithmetic ops via integer add/subtract truncated to two bits.
  function automatic logic [1:0] model(input logic [2:0] op, input logic ia, input logic ib,
                                       input logic ic);
    int s;
    case (op)
      3'd0:    return {1'b0, ia & ib};
      3'd1:    return {1'b0, ~ia};
      3'd2:    return {1'b0, ia | ib};
      3'd3:    return {1'b0, ia ^ ib};
      3'd4: begin
        s = int'(ia) + int'(ib) + int'(ic);
        return s[1:0];
      end
      3'd5: begin
        s = int'(ia) - int'(ib) - int'(ic);
        return s[1:0];
      end
      3'd6:    return {1'b0, ia};
      default: return {1'b0, ~ia};
    endcase
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {cout,out}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [2:0] op, input logic ia,
                         input logic ib, input logic ic, input logic [1:0] exp);
    vec_t v;
    v.name = name;
    v.op   = op;
    v.a    = ia;
    v.b    = ib;
    v.cin  = ic;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [2:0] op, input logic ia, input logic ib, input logic ic);
    select   = op;
    a        = ia;
    b        = ib;
    carry_in = ic;
  endtask

  // Drive at negedge, check comb instance at once, registered instance after the edge.
  task automatic apply(input vec_t v);
    sb_t e;
    @(negedge clk);
    drive(v.op, v.a, v.b, v.cin);
    e.name = v.name;
    e.exp  = v.exp;
    sb.push_back(e);
    #1;
    check({v.name, "/comb"}, {cout_comb, out_comb}, v.exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s/reg: scoreboard empty, got %b expected an entry", v.name,
               {cout_reg, out_reg});
    end else begin
      e = sb.pop_front();
      check({e.name, "/reg"}, {cout_reg, out_reg}, e.exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(3'd4, 1'b1, 1'b1, 1'b1);

    for (int op = 0; op < 8; op++)
      for (int i = 0; i < 8; i++)
        add_vec($sformatf("sweep_op%0d_abc%0d", op, i), 3'(op), i[2], i[1], i[0],
                model(3'(op), i[2], i[1], i[0]));
    add_vec("add_111",  3'd4, 1'b1, 1'b1, 1'b1, 2'b11);
    add_vec("add_100",  3'd4, 1'b1, 1'b0, 1'b0, 2'b01);
    add_vec("sub_010",  3'd5, 1'b0, 1'b1, 1'b0, 2'b11);
    add_vec("sub_101",  3'd5, 1'b1, 1'b0, 1'b1, 2'b00);
    add_vec("sub_111",  3'd5, 1'b1, 1'b1, 1'b1, 2'b11);
    add_vec("and_101",  3'd0, 1'b1, 1'b0, 1'b1, 2'b00);
    add_vec("or_101",   3'd2, 1'b1, 1'b0, 1'b1, 2'b01);
    add_vec("xor_101",  3'd3, 1'b1, 1'b0, 1'b1, 2'b01);
    add_vec("not_101",  3'd1, 1'b1, 1'b0, 1'b1, 2'b00);
    add_vec("xfer_101", 3'd6, 1'b1, 1'b0, 1'b1, 2'b01);
    add_vec("test_101", 3'd7, 1'b1, 1'b0, 1'b1, 2'b00);

    // Reset state while held through edges.
    #1;
    check("reset_initial", {cout_reg, out_reg}, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", {cout_reg, out_reg}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset mid-cycle discards a loaded ADD result.
    @(negedge clk);
    drive(3'd4, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("rst_seq_loaded", {cout_reg, out_reg}, 2'b11);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_seq_async", {cout_reg, out_reg}, 2'b00);
    check("rst_seq_comb_live", {cout_comb, out_comb}, 2'b11);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_seq_hold", {cout_reg, out_reg}, 2'b00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_seq_release_no_edge", {cout_reg, out_reg}, 2'b00);
    @(posedge clk);
    #1;
    check("rst_seq_first_edge", {cout_reg, out_reg}, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
